logic_seq_unit: RTL and testbench

Multi-cycle, parametrised bitwise logic unit; successor to the fixed 32-bit AND/OR/NOR/INV gate arrays. It latches two operands and an opcode on a start handshake and evaluates the result one slice per clock into a result register, then pulses DONE. It sits beside the ALU datapath and serves wide or area-constrained logic operations where a full-width single-cycle array is not wanted.

---
 rtl/logic_seq_unit.sv | 140 ++++++++++++++
 tb/tb_logic_seq_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_seq_unit.sv
// Sequential bitwise logic unit: latches OP1/OP2/OPRN on START, evaluates one slice per clock into Y.
// Latency: DONE pulses NUM_SLICES edges after the START sample; back-to-back issue every NUM_SLICES+2 cycles.
// Backpressure: none; START is only sampled in IDLE and is ignored (not queued) while BUSY.
//
// Ports: CLK/RST (async active-low) clock and reset; START request; OPRN opcode
//        (00 AND, 01 OR, 10 NOR, 11 INV of OP1); OP1/OP2 operands; Y result register;
//        BUSY high in RUN and DONE; DONE one-cycle completion pulse; ZERO result-is-zero flag.
// Optional feature: define LOGIC_SEQ_UNIT_ZERO_FLAG_EN to build the ZERO flag; otherwise ZERO is tied to 0.
module logic_seq_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [1:0]            OPRN,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ZERO
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SLICES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [1:0]            op_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  capture;
    logic                  last_slice;
    int                    base;
    logic [SLICE_WIDTH-1:0] a_sl;
    logic [SLICE_WIDTH-1:0] b_sl;
    logic [SLICE_WIDTH-1:0] r_sl;

    assign capture    = (state == S_IDLE) && START;
    assign last_slice = (state == S_RUN) && (cnt == CNT_LAST);

    // Slice datapath works only on the captured copies, so input churn after capture is harmless.
    always_comb begin
        base = int'(cnt) * SLICE_WIDTH;
        a_sl = a_q[base +: SLICE_WIDTH];
        b_sl = b_q[base +: SLICE_WIDTH];
        case (op_q)
            2'b00:   r_sl = a_sl & b_sl;
            2'b01:   r_sl = a_sl | b_sl;
            2'b10:   r_sl = ~(a_sl | b_sl);
            default: r_sl = ~a_sl;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            Y      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_q    <= OP1;
                        b_q    <= OP2;
                        op_q   <= OPRN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    Y[base +: SLICE_WIDTH] <= r_sl;
                    if (cnt == CNT_LAST) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;

`ifdef LOGIC_SEQ_UNIT_ZERO_FLAG_EN
    // Sticky OR of every slice written so far; the last slice is folded in directly
    // so ZERO lands on the same edge as DONE.
    logic acc_q;
    logic zero_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (capture) begin
            acc_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == S_RUN) begin
            acc_q <= acc_q | (|r_sl);
            if (last_slice) begin
                zero_q <= ~(acc_q | (|r_sl));
            end
        end
    end

    assign ZERO = zero_q;
`else
    assign ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_logic_seq_unit.sv
module tb_logic_seq_unit;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [1:0]  OPRN;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [31:0] Y;
    logic        BUSY;
    logic        DONE;
    logic        ZERO;

    logic        start64;
    logic [1:0]  oprn64;
    logic [63:0] op1_64;
    logic [63:0] op2_64;
    logic [63:0] y_w;
    logic        busy_w;
    logic        done_w;
    logic        zero_w;
    logic [63:0] y_n;
    logic        busy_n;
    logic        done_n;
    logic        zero_n;

    int checks = 0;
    int errors = 0;

    logic_seq_unit u_dut (
        .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
        .Y(Y), .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO)
    );

    logic_seq_unit #(.DATA_WIDTH(64), .SLICE_WIDTH(64)) u_wide (
        .CLK(CLK), .RST(RST), .START(start64), .OPRN(oprn64), .OP1(op1_64), .OP2(op2_64),
        .Y(y_w), .BUSY(busy_w), .DONE(done_w), .ZERO(zero_w)
    );

    logic_seq_unit #(.DATA_WIDTH(64), .SLICE_WIDTH(16)) u_narrow (
        .CLK(CLK), .RST(RST), .START(start64), .OPRN(oprn64), .OP1(op1_64), .OP2(op2_64),
        .Y(y_n), .BUSY(busy_n), .DONE(done_n), .ZERO(zero_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full-width reference: the whole result at once, masked to the operand width.
    function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] o, input int w);
        logic [63:0] r;
        logic [63:0] mask;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (o)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = ~(a | b);
            default: r = ~a;
        endcase
        return r & mask;
    endfunction

    function automatic logic zero_exp(input logic [63:0] y);
`ifdef LOGIC_SEQ_UNIT_ZERO_FLAG_EN
        return (y == 64'd0);
`else
        return 1'b0 & y[0];
`endif
    endfunction

    // Called at #1 after an edge with the 32-bit unit idle; returns at #1 after it is idle again.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input bit churn);
        logic [63:0] exp_full;
        logic [31:0] exp_y;
        logic        exp_z;
        int          k;
        exp_full = ref_op({32'd0, a}, {32'd0, b}, o, 32);
        exp_y    = exp_full[31:0];
        exp_z    = zero_exp(exp_full);
        OP1 = a; OP2 = b; OPRN = o; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("busy_on_capture", {63'd0, BUSY}, 64'd1);
        chk("zero_clear_on_capture", {63'd0, ZERO}, 64'd0);
        k = 0;
        while (DONE !== 1'b1 && k < 20) begin
            if (churn) begin
                OP1 = $urandom; OP2 = $urandom; OPRN = 2'($urandom_range(0, 3));
            end
            chk("busy_in_run", {63'd0, BUSY}, 64'd1);
            @(posedge CLK); #1;
            k++;
        end
        chk("done_latency", 64'(k), 64'd4);
        chk("y_at_done", {32'd0, Y}, {32'd0, exp_y});
        chk("busy_at_done", {63'd0, BUSY}, 64'd1);
        chk("zero_at_done", {63'd0, ZERO}, {63'd0, exp_z});
        @(posedge CLK); #1;
        chk("done_one_cycle", {63'd0, DONE}, 64'd0);
        chk("busy_after_done", {63'd0, BUSY}, 64'd0);
        chk("y_hold", {32'd0, Y}, {32'd0, exp_y});
        chk("zero_hold", {63'd0, ZERO}, {63'd0, exp_z});
    endtask

    // Drives both 64-bit units together; expects DONE after 1 edge (wide) and 4 edges (narrow).
    task automatic do_op64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] o);
        logic [63:0] exp_y;
        logic [63:0] yw_at;
        logic [63:0] yn_at;
        int          kw;
        int          kn;
        exp_y = ref_op(a, b, o, 64);
        kw = 0; kn = 0; yw_at = '0; yn_at = '0;
        op1_64 = a; op2_64 = b; oprn64 = o; start64 = 1'b1;
        @(posedge CLK); #1;
        start64 = 1'b0;
        op1_64 = {$urandom, $urandom}; op2_64 = {$urandom, $urandom};
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLK); #1;
            if (done_w && kw == 0) begin kw = k; yw_at = y_w; end
            if (done_n && kn == 0) begin kn = k; yn_at = y_n; end
        end
        chk("w64_latency", 64'(kw), 64'd1);
        chk("n64_latency", 64'(kn), 64'd4);
        chk("w64_y", yw_at, exp_y);
        chk("n64_y", yn_at, exp_y);
        chk("w64_idle", {62'd0, busy_w, done_w}, 64'd0);
        chk("n64_idle", {62'd0, busy_n, done_n}, 64'd0);
    endtask

    initial begin
        RST = 1'b0; START = 1'b0; OPRN = 2'b00; OP1 = '0; OP2 = '0;
        start64 = 1'b0; oprn64 = 2'b00; op1_64 = '0; op2_64 = '0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_y", {32'd0, Y}, 64'd0);
        chk("rst_flags", {61'd0, BUSY, DONE, ZERO}, 64'd0);
        chk("rst_w64", {y_w[62:0], busy_w | done_w | zero_w}, 64'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Reset in the middle of a run: slices 0 and 1 written, then abort.
        OP1 = 32'hFFFF_FFFF; OP2 = 32'hFFFF_FFFF; OPRN = 2'b00; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("partial_y", {32'd0, Y}, 64'h0000_FFFF);
        RST = 1'b0;
        #1;
        chk("midrun_rst_y", {32'd0, Y}, 64'd0);
        chk("midrun_rst_flags", {61'd0, BUSY, DONE, ZERO}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        do_op(32'hDEAD_BEEF, 32'h0, 2'b01, 1'b0);

        // Directed operations.
        do_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b00, 1'b0);
        do_op(32'h0000_00FF, 32'h0000_FF00, 2'b10, 1'b1);
        do_op(32'hAAAA_AAAA, 32'h5555_5555, 2'b00, 1'b0);
        do_op(32'hFFFF_FFFE, 32'h1234_5678, 2'b11, 1'b0);

        // START held high: captures every NUM_SLICES+2 = 6 edges.
        OP1 = 32'h1; OP2 = 32'h2; OPRN = 2'b01; START = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(posedge CLK); #1;
            chk("held_done", {63'd0, DONE}, {63'd0, (i % 6) == 5});
            chk("held_busy", {63'd0, BUSY}, {63'd0, (i % 6) != 0});
            if (DONE) chk("held_y", {32'd0, Y}, 64'h3);
        end
        START = 1'b0;
        @(posedge CLK); #1;
        chk("held_release_idle", {63'd0, BUSY}, 64'd0);

        // Randomised operations with and without input churn.
        for (int i = 0; i < 12; i++) begin
            do_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Parametrised instances.
        do_op64(64'h1, 64'h8000_0000_0000_0000, 2'b01);
        do_op64({$urandom, $urandom}, {$urandom, $urandom}, 2'b00);
        do_op64({$urandom, $urandom}, {$urandom, $urandom}, 2'b10);
        do_op64({$urandom, $urandom}, 64'd0, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
